// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the 3-stage global-stall pipeline and its sink.
package pipeline_pkg;

  localparam int DATA_W     = 32;
  localparam int PIPE_DEPTH = 3;

  // Occupancy counters need one bit more than the pointers so that "full" is representable.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sink_fifo_mem.sv
// DEPTH x WIDTH storage for the pipeline sink: one synchronous write port, one asynchronous read port.
module sink_fifo_mem
  import pipeline_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Capture one entry per cycle; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Fall-through read so the head entry is visible without a read cycle.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pipeline_sink.sv
// Output-side receiver: buffers pipeline results, drives global stall, and times the flush pulse.
module pipeline_sink
  import pipeline_pkg::*;
#(
  parameter int WIDTH      = pipeline_pkg::DATA_W,
  parameter int DEPTH      = 8,
  parameter int SKID       = 2,
  parameter int PIPE_DEPTH = pipeline_pkg::PIPE_DEPTH,
  localparam int CW        = pipeline_pkg::count_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pipe_data,
  input  logic             pipe_valid,
  output logic             stall,
  output logic             flush,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(PIPE_DEPTH + 1);

  localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL  = CW'(DEPTH - SKID);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(PIPE_DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          overflow_q, overflow_d;

  logic full;
  logic push;
  logic pop;
  logic drop;

  // Accept/drop/pop qualification; clear and flush discard anything in flight.
  always_comb begin
    full = (count_q == FULL_LVL);
    push = pipe_valid && !full && !clear && !flush;
    drop = pipe_valid &&  full && !clear && !flush;
    pop  = out_valid && out_ready && !clear;
  end

  // Next-state for pointers, occupancy, flush timer and sticky overflow.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    flush_cnt_d = flush_cnt_q;
    overflow_d  = overflow_q || drop;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (flush_cnt_q != '0) begin
        flush_cnt_d = flush_cnt_q - FW'(1);
      end
    end
  end

  // State register; reset takes effect immediately, independent of the clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flush_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flush_cnt_q <= flush_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  sink_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (pipe_data),
    .rd_addr (rd_ptr_q),
    .rd_data (out_data)
  );

  // Status outputs are decoded only from registered state, so they are glitch-free.
  always_comb begin
    out_valid = (count_q != '0);
    stall     = (count_q >= STALL_LVL);
    flush     = (flush_cnt_q != '0);
    count     = count_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_pipeline_sink.sv
// Directed bench for pipeline_sink with DEPTH=8, SKID=2, PIPE_DEPTH=3.
module tb_pipeline_sink;

  logic        clk;
  logic        reset;
  logic [31:0] pipe_data;
  logic        pipe_valid;
  logic        stall;
  logic        flush;
  logic        clear;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        overflow;

  int n_cmp;
  int n_bad;

  pipeline_sink #(
    .WIDTH      (32),
    .DEPTH      (8),
    .SKID       (2),
    .PIPE_DEPTH (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_data  (pipe_data),
    .pipe_valid (pipe_valid),
    .stall      (stall),
    .flush      (flush),
    .clear      (clear),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++;
    if (flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++;
    $display("test_reset: count=%0d out_valid=%b stall=%b flush=%b overflow=%b", count, out_valid, stall, flush, overflow);
  endtask

  task automatic test_basic_flow();
    logic [31:0] vals [3];
    vals[0] = 32'hA1; vals[1] = 32'hA2; vals[2] = 32'hA3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pipe_valid = 1'b1;
      pipe_data  = vals[i];
      tick();
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        n_bad++; $display("FAIL basic_data[%0d]: got %h valid=%b want %h", i, out_data, out_valid, vals[i]);
      end
      n_cmp++;
      if (count !== 4'd1) begin n_bad++; $display("FAIL basic_count[%0d]: got %0d want 1", i, count); end
      n_cmp++;
      $display("test_basic_flow: wrote %h out_data=%h count=%0d", vals[i], out_data, count);
    end
    pipe_valid = 1'b0;
    tick();
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_drain: got count=%0d valid=%b want 0/0", count, out_valid);
    end
    n_cmp++;
    $display("test_basic_flow: drained count=%0d", count);
  endtask

  // Pushes 0x100.. with no draining; the pipeline emits one skid result after stall rises.
  task automatic test_fill_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pipe_valid = 1'b1;
      pipe_data  = 32'h100 + i;
      tick();
      if (count !== 4'(i + 1)) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
      n_cmp++;
      if (stall !== (i + 1 >= 6)) begin n_bad++; $display("FAIL fill_stall[%0d]: got %b want %b", i, stall, (i + 1 >= 6)); end
      n_cmp++;
      $display("test_fill_stall: push %h count=%0d stall=%b", pipe_data, count, stall);
    end
    pipe_data = 32'h106;
    tick();
    pipe_valid = 1'b0;
    tick();
    if (count !== 4'd7) begin n_bad++; $display("FAIL fill_skid_count: got %0d want 7", count); end
    n_cmp++;
    if (stall !== 1'b1) begin n_bad++; $display("FAIL fill_skid_stall: got %b want 1", stall); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_overflow: got %b want 0", overflow); end
    n_cmp++;
    $display("test_fill_stall: after skid count=%0d stall=%b overflow=%b", count, stall, overflow);
  endtask

  task automatic test_overflow();
    logic seen_dead;
    seen_dead = 1'b0;
    pipe_valid = 1'b1;
    pipe_data  = 32'h107;
    tick();
    if (count !== 4'd8) begin n_bad++; $display("FAIL ovf_full_count: got %0d want 8", count); end
    n_cmp++;
    pipe_data = 32'hDEAD;
    tick();
    pipe_valid = 1'b0;
    if (count !== 4'd8) begin n_bad++; $display("FAIL ovf_count: got %0d want 8", count); end
    n_cmp++;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++;
    $display("test_overflow: pushed DEAD while full count=%0d overflow=%b", count, overflow);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_data === 32'hDEAD) seen_dead = 1'b1;
      if (out_data !== 32'h100 + i) begin n_bad++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, out_data, 32'h100 + i); end
      n_cmp++;
      $display("test_overflow: drain out_data=%h", out_data);
      tick();
    end
    out_ready = 1'b0;
    if (seen_dead !== 1'b0) begin n_bad++; $display("FAIL ovf_dead_seen: got %b want 0", seen_dead); end
    n_cmp++;
    if (count !== 4'd0 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_sticky: got count=%0d overflow=%b want 0/1", count, overflow);
    end
    n_cmp++;
    $display("test_overflow: after drain count=%0d overflow=%b", count, overflow);
  endtask

  task automatic test_clear_mid_fill();
    int flush_cycles;
    flush_cycles = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pipe_valid = 1'b1;
      pipe_data  = 32'h200 + i;
      tick();
    end
    if (count !== 4'd5) begin n_bad++; $display("FAIL clr_pre_count: got %0d want 5", count); end
    n_cmp++;
    clear     = 1'b1;
    out_ready = 1'b1;
    pipe_data = 32'h2FF;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (flush === 1'b1) flush_cycles++;
      if (count !== 4'd0) begin n_bad++; $display("FAIL clr_count[%0d]: got %0d want 0", i, count); end
      n_cmp++;
      $display("test_clear_mid_fill: flush cycle %0d flush=%b count=%0d", i, flush, count);
      pipe_data = 32'h300 + i;
      tick();
    end
    if (flush_cycles !== 3 || flush !== 1'b0) begin
      n_bad++; $display("FAIL clr_flush_len: got %0d cycles flush_now=%b want 3/0", flush_cycles, flush);
    end
    n_cmp++;
    pipe_data = 32'h303;
    tick();
    pipe_valid = 1'b0;
    if (count !== 4'd1 || out_data !== 32'h303) begin
      n_bad++; $display("FAIL clr_capture: got count=%0d data=%h want 1/303", count, out_data);
    end
    n_cmp++;
    $display("test_clear_mid_fill: post-flush capture count=%0d out_data=%h", count, out_data);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    out_ready  = 1'b0;
    pipe_valid = 1'b1;
    pipe_data  = 32'h400;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pipe_data = 32'h401 + i;
      tick();
      if (count !== 4'd1 || out_data !== 32'h401 + i) begin
        n_bad++; $display("FAIL wrap[%0d]: got count=%0d data=%h want 1/%h", i, count, out_data, 32'h401 + i);
      end
      n_cmp++;
      $display("test_wrap: cycle %0d out_data=%h count=%0d", i, out_data, count);
    end
    pipe_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    if (count !== 4'd0) begin n_bad++; $display("FAIL wrap_drain: got %0d want 0", count); end
    n_cmp++;
  endtask

  task automatic test_async_reset();
    pipe_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pipe_data = 32'h500 + i;
      tick();
    end
    pipe_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    if (count !== 4'd0 || out_valid !== 1'b0 || stall !== 1'b0 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL areset_fill: got count=%0d valid=%b stall=%b ovf=%b want all 0", count, out_valid, stall, overflow);
    end
    n_cmp++;
    $display("test_async_reset: mid-fill reset count=%0d overflow=%b", count, overflow);
    tick();
    reset = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    if (flush !== 1'b1) begin n_bad++; $display("FAIL areset_flush_pre: got %b want 1", flush); end
    n_cmp++;
    #2;
    reset = 1'b1;
    #1;
    if (flush !== 1'b0 || count !== 4'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL areset_flush: got flush=%b count=%0d valid=%b want 0/0/0", flush, count, out_valid);
    end
    n_cmp++;
    $display("test_async_reset: mid-flush reset flush=%b", flush);
    tick();
    reset = 1'b0;
    tick();
    if (flush !== 1'b0) begin n_bad++; $display("FAIL areset_release: got flush=%b want 0", flush); end
    n_cmp++;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    pipe_data  = '0;
    pipe_valid = 1'b0;
    clear      = 1'b0;
    out_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_basic_flow();
    test_fill_stall();
    test_overflow();
    test_clear_mid_fill();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_sink.md
# pipeline_sink

Output-side receiver for the 3-stage global-stall pipeline. It captures every result presented on the pipeline's output/valid pair into a small FIFO, drives the pipeline's global `stall` from FIFO occupancy, and generates the multi-cycle `flush` pulse on a downstream clear request. Downstream logic drains results through a standard valid/ready port.

## Interface

Parameters:
- `WIDTH`, 32: data width; matches the pipeline data path.
- `DEPTH`, 8: FIFO entries; power of two, at least 4.
- `SKID`, 2: free entries reserved when `stall` asserts. Legal range is 1 to DEPTH-1.
- `PIPE_DEPTH`, 3: number of cycles `flush` is held after a clear.

Ports (clock and reset first):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `pipe_data` in WIDTH: pipeline stage-3 result.
- `pipe_valid` in 1: pipeline stage-3 valid.
- `stall` out 1: global stall to the pipeline.
- `flush` out 1: flush to the pipeline.
- `clear` in 1: downstream request to discard all buffered and in-flight results.
- `out_data` out WIDTH: head-of-FIFO data.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: downstream accepts the head entry.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky flag; a valid result was dropped because the FIFO was full.

## Operation

- Write rule: the block writes `pipe_data` at the clock edge when all of the following hold: `pipe_valid` is high, `full` (count==DEPTH) is low, `clear` is low, and `flush` is low.
- Drop rule: if `pipe_valid` is high while full, and `clear` and `flush` are both low, the data is dropped and `overflow` is set. `overflow` clears only on `reset`.
- Read rule: the head entry is popped at the edge when `out_valid && out_ready`. `out_data` shows `mem[rd_ptr]` combinationally (first-word fall-through). Its value is don't-care when the FIFO is empty.
- Simultaneous push and pop: `count` stays the same and both pointers advance. The full check uses the registered count, so a push while full is dropped even if a pop happens in the same cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Stall: `stall = (count >= DEPTH-SKID)`, decoded combinationally from the registered count.
- Clear: `clear` high for one cycle produces the following at the next edge:
  - `count` goes to 0 and `rd_ptr` and `wr_ptr` go to 0.
  - Any pop requested in that cycle is ignored.
  - A down-counter loads PIPE_DEPTH, and `flush` is registered high while the counter is non-zero, which gives exactly PIPE_DEPTH cycles.
- `clear` arriving while `flush` is already high reloads the counter, which extends the flush.
- Pops remain legal while `flush` is high.
- Flush has priority over stall. `stall` is still computed from `count`, and `count` is 0 after a clear.

## Timing

- Values after reset: `count`=0, `out_valid`=0, `stall`=0, `flush`=0, `overflow`=0, pointers=0.
- Latency from a pipeline result to `out_valid` is 1 cycle: write at edge N, `out_valid` high after edge N.
- `stall` asserts in the same cycle that `count` reaches DEPTH-SKID. The pipeline zeroes its valid at the next edge, so at most one more result arrives after `stall` first asserts. That result always fits because SKID≥1.
- Latency from `clear` to `flush` is 1 cycle. `flush` is high for cycles N+1 through N+PIPE_DEPTH.
- A `reset` asserted in the middle of a flush or a fill returns every state to its reset value immediately and asynchronously.

## Structure

- Shared package `pipeline_pkg`: `DATA_W`=32, `PIPE_DEPTH`=3, and the `count` width function. The same constants are used by `pipeline_unit` and any future stages.
- One sub-module, `sink_fifo_mem`: a DEPTH×WIDTH register array with one write port and an asynchronous read port.
- `pipeline_sink` holds the pointers, count, stall decode, flush counter, and overflow flag.

## Test plan

1. Basic flow: after reset, drive `pipe_valid` for 3 cycles with 0xA1, 0xA2, 0xA3 while `out_ready`=1. Required response: `out_data` shows 0xA1, 0xA2, 0xA3 in order, each one cycle after its write, and `count` never exceeds 1.
2. Fill and stall (DEPTH=8, SKID=2): push continuously with `out_ready`=0. Required response: `stall` rises when `count`=6, at most one further write follows, `count` is ≤7, and `overflow`=0.
3. Overflow: force `pipe_valid` high with `stall` ignored until `count`=8, then push 0xDEAD. Required response: `count` stays 8, `overflow`=1 and remains 1 after draining, and 0xDEAD never appears on `out_data`.
4. Clear mid-fill: with `count`=5, pulse `clear` while `pipe_valid`=1 and `out_ready`=1. Required response: `count`=0 after the edge, `flush` is high for exactly 3 cycles, results presented during those 3 cycles are discarded, and a result presented on the 4th cycle is captured.
5. Wrap-around: across 20 push/pop cycles, interleave simultaneous push and pop at `count`=1. Required response: data order is preserved across pointer wrap and `count` stays constant on simultaneous push/pop cycles.
6. Async reset: assert `reset` mid-cycle while `flush` is active and `count`=4. Required response: all outputs go to their reset values immediately, before the next clock edge.
